ca_line_engine: RTL and testbench

CA_LINE_ENGINE -- requirements
Module: ca_line_engine

---
 rtl/ca_line_if.sv | 27 ++
 rtl/ca_line_engine.sv | 164 ++++++++++++++++
 tb/tb_ca_line_engine.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ca_line_if.sv
// Bus interface for ca_line_engine: control handshake, generation status and the display read port.
`timescale 1ns/1ps
interface ca_line_if #(
    parameter int unsigned WIDTH = 64
) ();
    localparam int unsigned AW = $clog2(WIDTH);

    logic          ena;
    logic [7:0]    rule;
    logic          start;
    logic          init;
    logic          busy;
    logic          done;
    logic [15:0]   gen_count;
    logic [AW-1:0] rd_addr;
    logic          rd_pixel;

    modport master (
        output ena, rule, start, init, rd_addr,
        input  busy, done, gen_count, rd_pixel
    );

    modport slave (
        input  ena, rule, start, init, rd_addr,
        output busy, done, gen_count, rd_pixel
    );
endinterface

// File: rtl/ca_line_engine.sv
// Elementary 1-D cellular automaton engine: computes one cell per cycle into a back row, then swaps it to the front.
// Optional macro CA_RANDOM_SEED_EN adds a 16-bit LFSR whose contents become the seed row on init.
`timescale 1ns/1ps
module ca_line_engine #(
    parameter int unsigned WIDTH = 64,
    parameter bit          WRAP  = 1'b1
) (
    input  logic     clk,
    input  logic     rst_n,
    ca_line_if.slave bus
);
    localparam int unsigned   AW   = $clog2(WIDTH);
    localparam logic [AW-1:0] LAST = AW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] SEED = WIDTH'(1) << (WIDTH / 2);

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_SWAP} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_front;
    logic [WIDTH-1:0] r_back;
    logic [AW-1:0]    r_idx;
    logic [7:0]       r_rule;
    logic             r_busy;
    logic             r_done;
    logic [15:0]      r_gen;
    logic             r_pixel;

    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_latch;
    logic             w_write;
    logic             w_swap;
    logic             w_init;
    logic             w_left;
    logic             w_center;
    logic             w_right;
    logic             w_cell;
    logic [WIDTH-1:0] w_seed;

`ifdef CA_RANDOM_SEED_EN
    logic [15:0] r_lfsr;
    logic        w_fb;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting toward bit 0.
    assign w_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= 16'hACE1;
        end else if (bus.ena) begin
            r_lfsr <= {w_fb, r_lfsr[15:1]};
        end
    end

    // Row bit i takes lfsr bit (i mod 16).
    assign w_seed = WIDTH'({(WIDTH / 16 + 1){r_lfsr}});
`else
    assign w_seed = SEED;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // init overrides everything; otherwise the FSM advances only on enabled cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_latch     = 1'b0;
        w_write     = 1'b0;
        w_swap      = 1'b0;
        w_init      = 1'b0;
        if (bus.init) begin
            w_init      = 1'b1;
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
        end else if (bus.ena) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        w_latch     = 1'b1;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    w_write = 1'b1;
                    if (r_idx == LAST) begin
                        w_state_nxt = S_SWAP;
                    end
                end
                S_SWAP: begin
                    w_swap      = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Neighbourhood of the current cell; out-of-row neighbours wrap or read 0.
    always_comb begin
        w_center = r_front[r_idx];
        w_left   = (r_idx == '0)  ? (WRAP ? r_front[WIDTH-1] : 1'b0) : r_front[r_idx - AW'(1)];
        w_right  = (r_idx == LAST) ? (WRAP ? r_front[0] : 1'b0)      : r_front[r_idx + AW'(1)];
        w_cell   = r_rule[{w_left, w_center, w_right}];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_front <= SEED;
            r_back  <= '0;
            r_idx   <= '0;
            r_rule  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_gen   <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            if (w_init) begin
                r_front <= w_seed;
                r_back  <= '0;
                r_gen   <= '0;
                r_idx   <= '0;
            end else begin
                if (w_latch) begin
                    r_rule <= bus.rule;
                    r_idx  <= '0;
                end
                if (w_write) begin
                    r_back[r_idx] <= w_cell;
                    r_idx         <= (r_idx == LAST) ? '0 : r_idx + AW'(1);
                end
                if (w_swap) begin
                    r_front <= r_back;
                    r_gen   <= r_gen + 16'd1;
                end
            end
        end
    end

    // Display read port, independent of ena and FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pixel <= 1'b0;
        end else begin
            r_pixel <= (32'(bus.rd_addr) < WIDTH) ? r_front[bus.rd_addr] : 1'b0;
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.gen_count = r_gen;
    assign bus.rd_pixel  = r_pixel;
endmodule

// File: tb/tb_ca_line_engine.sv
// Self-checking bench for ca_line_engine: directed handshake cases plus randomized rules against a row-level model.
`timescale 1ns/1ps
module tb_ca_line_engine;
    localparam logic [63:0] SEED64 = 64'h1 << 32;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ca_line_if #(.WIDTH(64)) b64 ();
    ca_line_if #(.WIDTH(8))  b8w ();
    ca_line_if #(.WIDTH(8))  b8n ();

    ca_line_engine #(.WIDTH(64), .WRAP(1'b1)) u64 (.clk(clk), .rst_n(rst_n), .bus(b64.slave));
    ca_line_engine #(.WIDTH(8),  .WRAP(1'b1)) u8w (.clk(clk), .rst_n(rst_n), .bus(b8w.slave));
    ca_line_engine #(.WIDTH(8),  .WRAP(1'b0)) u8n (.clk(clk), .rst_n(rst_n), .bus(b8n.slave));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Next row from the elementary-CA rule applied to each neighbourhood.
    function automatic logic [63:0] model_step(input logic [63:0] row, input int w, input bit wrap,
                                               input logic [7:0] rl);
        logic [63:0] nxt;
        int l, c, r, nb;
        nxt = '0;
        for (int i = 0; i < w; i++) begin
            c  = int'(row[6'(i)]);
            l  = (!wrap && i == 0)     ? 0 : int'(row[6'((i + w - 1) % w)]);
            r  = (!wrap && i == w - 1) ? 0 : int'(row[6'((i + 1) % w)]);
            nb = 4 * l + 2 * c + r;
            nxt[6'(i)] = rl[3'(nb)];
        end
        return nxt;
    endfunction

    function automatic logic [63:0] lfsr_row(input int n);
        int s, b;
        logic [63:0] row;
        s = 'hACE1;
        for (int k = 0; k < n; k++) begin
            b = ((s >> 0) ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
            s = (s >> 1) | (b << 15);
        end
        for (int i = 0; i < 64; i++) row[6'(i)] = 1'((s >> (i % 16)) & 1);
        return row;
    endfunction

    task automatic read_px(input int a, output logic p);
        b64.rd_addr = 6'(a);
        tick();
        p = b64.rd_pixel;
    endtask

    task automatic read_row64(output logic [63:0] row);
        row = '0;
        for (int i = 0; i < 64; i++) begin
            b64.rd_addr = 6'(i);
            tick();
            row[6'(i)] = b64.rd_pixel;
        end
    endtask

    // Pulses start, then runs a bounded window recording when done shows up and how often.
    task automatic run_gen(input logic [7:0] rl, input int gap_at, input int gap_len, input int again_at,
                           input int init_at, input int cycles,
                           output int first_done, output int ndone, output logic busy0);
        b64.rule  = rl;
        b64.start = 1'b1;
        tick();
        busy0      = b64.busy;
        b64.start  = 1'b0;
        b64.rule   = 8'($urandom);
        first_done = -1;
        ndone      = 0;
        for (int k = 1; k <= cycles; k++) begin
            tick();
            if (b64.done === 1'b1) begin
                ndone++;
                if (first_done < 0) first_done = k;
            end
            b64.start   = 1'b0;
            b64.init    = 1'b0;
            b64.rule    = 8'($urandom);
            b64.rd_addr = 6'($urandom);
            if (k == again_at) b64.start = 1'b1;
            if (k == init_at)  b64.init  = 1'b1;
            if (k == gap_at)   b64.ena   = 1'b0;
            if (k == gap_at + gap_len) b64.ena = 1'b1;
        end
        b64.start = 1'b0;
        b64.init  = 1'b0;
        b64.ena   = 1'b1;
    endtask

    logic [63:0] m, row;
    logic [7:0]  rw, rn, rl;
    logic        p, busy0;
    int          fd, nd, gap, gl, exp_gen, nsh;

    initial begin
        rst_n = 1'b0;
        b64.ena = 1'b1; b64.rule = '0; b64.start = 1'b0; b64.init = 1'b0; b64.rd_addr = '0;
        b8w.ena = 1'b1; b8w.rule = '0; b8w.start = 1'b0; b8w.init = 1'b0; b8w.rd_addr = '0;
        b8n.ena = 1'b1; b8n.rule = '0; b8n.start = 1'b0; b8n.init = 1'b0; b8n.rd_addr = '0;
        repeat (3) tick();
        chk("rst_busy", 64'(b64.busy), 64'd0);
        chk("rst_done", 64'(b64.done), 64'd0);
        chk("rst_gen", 64'(b64.gen_count), 64'd0);
        chk("rst_pixel", 64'(b64.rd_pixel), 64'd0);
        rst_n = 1'b1;
        read_px(32, p); chk("seed_px32", 64'(p), 64'd1);
        read_px(31, p); chk("seed_px31", 64'(p), 64'd0);
        read_px(33, p); chk("seed_px33", 64'(p), 64'd0);
        chk("seed_busy", 64'(b64.busy), 64'd0);
        chk("seed_gen", 64'(b64.gen_count), 64'd0);

        // Rule 90, single generation from the seed.
        run_gen(8'd90, 0, 0, 0, 0, 70, fd, nd, busy0);
        chk("r90_busy", 64'(busy0), 64'd1);
        chk("r90_latency", 64'(fd), 64'd65);
        chk("r90_ndone", 64'(nd), 64'd1);
        chk("r90_gen", 64'(b64.gen_count), 64'd1);
        chk("r90_busy_end", 64'(b64.busy), 64'd0);
        read_px(31, p); chk("r90_px31", 64'(p), 64'd1);
        read_px(33, p); chk("r90_px33", 64'(p), 64'd1);
        read_px(32, p); chk("r90_px32", 64'(p), 64'd0);
        read_row64(row);
        chk("r90_row", row, model_step(SEED64, 64, 1'b1, 8'd90));

        // Rule 30, 40 generations.
        b64.init = 1'b1; tick(); b64.init = 1'b0;
        chk("init_gen", 64'(b64.gen_count), 64'd0);
        m = SEED64;
        for (int g = 1; g <= 40; g++) begin
            run_gen(8'd30, 0, 0, 0, 0, 66, fd, nd, busy0);
            chk($sformatf("r30_lat_g%0d", g), 64'(fd), 64'd65);
            read_row64(row);
            m = model_step(m, 64, 1'b1, 8'd30);
            chk($sformatf("r30_row_g%0d", g), row, m);
        end
        chk("r30_gen", 64'(b64.gen_count), 64'd40);

        // Random rules with a random enable gap mid-generation.
        exp_gen = 40;
        for (int g = 0; g < 6; g++) begin
            rl  = 8'($urandom);
            gap = $urandom_range(2, 50);
            gl  = $urandom_range(1, 8);
            run_gen(rl, gap, gl, 0, 0, 80, fd, nd, busy0);
            chk($sformatf("rnd_lat_g%0d", g), 64'(fd), 64'(65 + gl));
            chk($sformatf("rnd_ndone_g%0d", g), 64'(nd), 64'd1);
            read_row64(row);
            m = model_step(m, 64, 1'b1, rl);
            exp_gen++;
            chk($sformatf("rnd_row_g%0d", g), row, m);
        end
        chk("rnd_gen", 64'(b64.gen_count), 64'(exp_gen));

        // Start while busy is ignored.
        run_gen(8'd30, 0, 0, 10, 0, 140, fd, nd, busy0);
        chk("again_ndone", 64'(nd), 64'd1);
        chk("again_lat", 64'(fd), 64'd65);
        chk("again_gen", 64'(b64.gen_count), 64'(exp_gen + 1));
        read_row64(row);
        chk("again_row", row, model_step(m, 64, 1'b1, 8'd30));

        // init mid-compute aborts.
        run_gen(8'd30, 0, 0, 0, 10, 140, fd, nd, busy0);
        chk("abort_ndone", 64'(nd), 64'd0);
        chk("abort_gen", 64'(b64.gen_count), 64'd0);
        chk("abort_busy", 64'(b64.busy), 64'd0);
        read_row64(row);
        chk("abort_row", row, SEED64);

        // init and start together: init wins.
        b64.rule = 8'd90; b64.init = 1'b1; b64.start = 1'b1;
        tick();
        b64.init = 1'b0; b64.start = 1'b0;
        chk("both_busy", 64'(b64.busy), 64'd0);
        nd = 0;
        for (int k = 0; k < 70; k++) begin
            tick();
            if (b64.done === 1'b1 || b64.busy === 1'b1) nd++;
        end
        chk("both_activity", 64'(nd), 64'd0);
        chk("both_gen", 64'(b64.gen_count), 64'd0);

        // Enable low for 5 cycles delays done by exactly 5.
        run_gen(8'd30, 10, 5, 0, 0, 90, fd, nd, busy0);
        chk("gap5_lat", 64'(fd), 64'd70);
        chk("gap5_ndone", 64'(nd), 64'd1);
        chk("gap5_gen", 64'(b64.gen_count), 64'd1);
        read_row64(row);
        chk("gap5_row", row, model_step(SEED64, 64, 1'b1, 8'd30));

        // Edge behaviour on 8-cell rows, 4 generations of rule 90.
        for (int g = 0; g < 4; g++) begin
            b8w.rule = 8'd90; b8n.rule = 8'd90;
            b8w.start = 1'b1; b8n.start = 1'b1;
            tick();
            b8w.start = 1'b0; b8n.start = 1'b0;
            repeat (12) tick();
        end
        rw = '0; rn = '0;
        for (int i = 0; i < 8; i++) begin
            b8w.rd_addr = 3'(i); b8n.rd_addr = 3'(i);
            tick();
            rw[3'(i)] = b8w.rd_pixel;
            rn[3'(i)] = b8n.rd_pixel;
        end
        chk("w8_wrap_row", 64'(rw), 64'h00);
        chk("w8_nowrap_row", 64'(rn), 64'h01);
        chk("w8_wrap_gen", 64'(b8w.gen_count), 64'd4);
        chk("w8_nowrap_gen", 64'(b8n.gen_count), 64'd4);

        // Reset mid-compute, then init after a random number of enabled cycles.
        b64.rule = 8'd30; b64.start = 1'b1; tick(); b64.start = 1'b0;
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(b64.busy), 64'd0);
        chk("midrst_gen", 64'(b64.gen_count), 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        nd = 0;
        nsh = 70 + $urandom_range(0, 30);
        for (int k = 0; k < nsh; k++) begin
            tick();
            if (b64.done === 1'b1) nd++;
        end
        chk("midrst_ndone", 64'(nd), 64'd0);
        b64.init = 1'b1; tick(); b64.init = 1'b0;
        read_row64(row);
`ifdef CA_RANDOM_SEED_EN
        chk("seed_cfg_row", row, lfsr_row(nsh));
`else
        chk("seed_cfg_row", row, SEED64);
`endif
        chk("seed_cfg_gen", 64'(b64.gen_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
